// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request queue: level encoding,
// queue geometry and controller state encoding.
package elevator_pkg;

    localparam int LVL_W       = 2;
    localparam int QUEUE_DEPTH = 4;
    localparam int TAIL_W      = 3;
    localparam int QIDX_W      = 2;

    localparam logic [LVL_W-1:0] LVL_A = 2'd0;
    localparam logic [LVL_W-1:0] LVL_B = 2'd1;
    localparam logic [LVL_W-1:0] LVL_C = 2'd2;
    localparam logic [LVL_W-1:0] LVL_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

endpackage

// File: rtl/pressed_lvl_in_queue_logic.sv
// Duplicate check: flags when the pressed level already sits in one of the
// valid queue entries (index below tail). Purely combinational.
module pressed_lvl_in_queue_logic
    import elevator_pkg::*;
(
    input  logic [LVL_W-1:0]             press_lvl,
    input  logic [QUEUE_DEPTH*LVL_W-1:0] queue,
    input  logic [TAIL_W-1:0]            tail,
    output logic                         in_queue
);

    // Compare the pressed level against every occupied entry
    always_comb begin
        in_queue = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if ((TAIL_W'(i) < tail) && (queue[i*LVL_W +: LVL_W] == press_lvl)) begin
                in_queue = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_queue_ctrl.sv
// Elevator request queue controller: accepts deduplicated floor presses into
// a 4-entry FIFO and services the head by stepping the car one level at a
// time, then holding the door open before dequeuing with a shift-up.
// Optional build macro: LVL_PRESS_EDGE_EN (accept presses only on the rising
// edge of press_valid, so a held button yields a single request).
module elevator_queue_ctrl
    import elevator_pkg::*;
#(
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         press_valid,
    input  logic [LVL_W-1:0]             press_lvl,
    output logic [LVL_W-1:0]             cur_lvl,
    output logic                         moving,
    output logic                         dir_up,
    output logic                         door_open,
    output logic [QUEUE_DEPTH*LVL_W-1:0] queue,
    output logic [TAIL_W-1:0]            tail,
    output logic                         full
);

    localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MOVE_LOAD = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [LVL_W-1:0]             lvl_q, lvl_d;
    logic [QUEUE_DEPTH*LVL_W-1:0] queue_q, queue_d;
    logic [TAIL_W-1:0]            tail_q, tail_d;

    logic                         press_req;
    logic                         in_queue;
    logic                         accept;
    logic                         deq;
    logic                         full_w;
    logic [LVL_W-1:0]             head;
    logic                         up;
    logic [LVL_W-1:0]             step_lvl;
    logic [QIDX_W-1:0]            wr_idx;

`ifdef LVL_PRESS_EDGE_EN
    logic press_valid_d;

    // Remember last cycle's button state to detect a fresh press
    always_ff @(posedge clk) begin
        if (rst) begin
            press_valid_d <= 1'b0;
        end else begin
            press_valid_d <= press_valid;
        end
    end

    assign press_req = press_valid & ~press_valid_d;
`else
    assign press_req = press_valid;
`endif

    pressed_lvl_in_queue_logic u_in_queue (
        .press_lvl (press_lvl),
        .queue     (queue_q),
        .tail      (tail_q),
        .in_queue  (in_queue)
    );

    assign full_w   = (tail_q == TAIL_W'(QUEUE_DEPTH));
    assign accept   = press_req & ~in_queue & ~full_w;
    assign head     = queue_q[LVL_W-1:0];
    assign up       = (head > lvl_q);
    assign step_lvl = up ? (lvl_q + LVL_W'(1)) : (lvl_q - LVL_W'(1));

    // Next-state logic: idle dispatch, per-level move timing, door hold
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        deq     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tail_q != '0) begin
                    if (head == lvl_q) begin
                        state_d = ST_DOOR;
                        cnt_d   = DOOR_LOAD;
                    end else begin
                        state_d = ST_MOVE;
                        cnt_d   = MOVE_LOAD;
                    end
                end
            end
            ST_MOVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    lvl_d = step_lvl;
                    if (step_lvl == head) begin
                        state_d = ST_DOOR;
                        cnt_d   = DOOR_LOAD;
                    end else begin
                        cnt_d = MOVE_LOAD;
                    end
                end
            end
            ST_DOOR: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    deq     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Queue update: shift-up on dequeue, append accepted press at the tail
    always_comb begin
        queue_d = queue_q;
        tail_d  = tail_q;
        wr_idx  = '0;
        if (deq) begin
            // Top entry keeps its stale value; it lies beyond tail afterwards
            queue_d[(QUEUE_DEPTH-1)*LVL_W-1:0] = queue_q[QUEUE_DEPTH*LVL_W-1:LVL_W];
            if (accept) begin
                wr_idx = tail_q[QIDX_W-1:0] - QIDX_W'(1);
                queue_d[int'(wr_idx)*LVL_W +: LVL_W] = press_lvl;
            end else begin
                tail_d = tail_q - TAIL_W'(1);
            end
        end else if (accept) begin
            wr_idx = tail_q[QIDX_W-1:0];
            queue_d[int'(wr_idx)*LVL_W +: LVL_W] = press_lvl;
            tail_d = tail_q + TAIL_W'(1);
        end
    end

    // State, counter, car level and queue registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lvl_q   <= LVL_A;
            queue_q <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            queue_q <= queue_d;
            tail_q  <= tail_d;
        end
    end

    assign cur_lvl   = lvl_q;
    assign moving    = (state_q == ST_MOVE);
    assign dir_up    = (state_q == ST_MOVE) & up;
    assign door_open = (state_q == ST_DOOR);
    assign queue     = queue_q;
    assign tail      = tail_q;
    assign full      = full_w;

endmodule

// File: tb/tb_elevator_queue_ctrl.sv
// Directed testbench for elevator_queue_ctrl with default timing parameters.
module tb_elevator_queue_ctrl;

    logic       clk;
    logic       rst;
    logic       press_valid;
    logic [1:0] press_lvl;
    logic [1:0] cur_lvl;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic [7:0] queue;
    logic [2:0] tail;
    logic       full;

    int n_checks = 0;
    int n_fail   = 0;

    elevator_queue_ctrl #(.MOVE_CYCLES(4), .DOOR_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .press_valid (press_valid),
        .press_lvl   (press_lvl),
        .cur_lvl     (cur_lvl),
        .moving      (moving),
        .dir_up      (dir_up),
        .door_open   (door_open),
        .queue       (queue),
        .tail        (tail),
        .full        (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait until the queue is empty and the car is parked, bounded
    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (tail == 3'd0 && !moving && !door_open) begin
                done = 1'b1;
                break;
            end
            step(1);
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: timeout waiting for idle, tail=%0d moving=%0b door=%0b", name, tail, moving, door_open);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; press_valid = 1'b0; press_lvl = 2'd0;
        step(2);
        rst = 1'b0;
        n_checks++; if (cur_lvl !== 2'd0) begin n_fail++; $display("FAIL reset_cur_lvl: got %0d want 0", cur_lvl); end
        n_checks++; if (queue !== 8'd0) begin n_fail++; $display("FAIL reset_queue: got %h want 00", queue); end
        n_checks++; if (tail !== 3'd0) begin n_fail++; $display("FAIL reset_tail: got %0d want 0", tail); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving: got %b want 0", moving); end
        n_checks++; if (door_open !== 1'b0) begin n_fail++; $display("FAIL reset_door: got %b want 0", door_open); end
        n_checks++; if (dir_up !== 1'b0) begin n_fail++; $display("FAIL reset_dir_up: got %b want 0", dir_up); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    endtask

    // From A, press C: two 4-cycle steps up, then 8 door cycles
    task automatic test_single_trip;
        int door_cnt;
        press_valid = 1'b1; press_lvl = 2'd2;
        step(1);
        press_valid = 1'b0;
        n_checks++; if (tail !== 3'd1) begin n_fail++; $display("FAIL trip_tail: got %0d want 1", tail); end
        n_checks++; if (queue[1:0] !== 2'd2) begin n_fail++; $display("FAIL trip_head: got %0d want 2", queue[1:0]); end
        step(1);
        n_checks++; if (moving !== 1'b1 || dir_up !== 1'b1) begin n_fail++; $display("FAIL trip_move_start: moving=%b dir_up=%b want 1,1", moving, dir_up); end
        n_checks++; if (cur_lvl !== 2'd0) begin n_fail++; $display("FAIL trip_lvl0: got %0d want 0", cur_lvl); end
        step(3);
        n_checks++; if (cur_lvl !== 2'd0) begin n_fail++; $display("FAIL trip_lvl_early: got %0d want 0", cur_lvl); end
        step(1);
        n_checks++; if (cur_lvl !== 2'd1 || moving !== 1'b1) begin n_fail++; $display("FAIL trip_lvl1: lvl=%0d moving=%b want 1,1", cur_lvl, moving); end
        step(4);
        n_checks++; if (cur_lvl !== 2'd2 || door_open !== 1'b1 || moving !== 1'b0) begin n_fail++; $display("FAIL trip_arrive: lvl=%0d door=%b moving=%b want 2,1,0", cur_lvl, door_open, moving); end
        door_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (door_open) door_cnt++;
            n_checks++; if (tail !== 3'd1) begin n_fail++; $display("FAIL trip_tail_in_door: got %0d want 1", tail); end
            step(1);
        end
        n_checks++; if (door_cnt != 8) begin n_fail++; $display("FAIL trip_door_cycles: got %0d want 8", door_cnt); end
        n_checks++; if (door_open !== 1'b0 || tail !== 3'd0) begin n_fail++; $display("FAIL trip_done: door=%b tail=%0d want 0,0", door_open, tail); end
    endtask

    // Car at C: repeat press of a queued level, then a held button on D
    task automatic test_dedup;
        press_valid = 1'b1; press_lvl = 2'd1;
        step(1);
        press_valid = 1'b0;
        step(1);
        press_valid = 1'b1; press_lvl = 2'd1;
        step(1);
        press_valid = 1'b0;
        n_checks++; if (tail !== 3'd1) begin n_fail++; $display("FAIL dedup_repeat_b: tail=%0d want 1", tail); end
        press_valid = 1'b1; press_lvl = 2'd3;
        step(5);
        press_valid = 1'b0;
        n_checks++; if (tail !== 3'd2) begin n_fail++; $display("FAIL dedup_held_d: tail=%0d want 2", tail); end
        n_checks++; if (queue[3:0] !== 4'b11_01) begin n_fail++; $display("FAIL dedup_queue: got %b want 1101", queue[3:0]); end
        wait_idle("dedup_drain");
        n_checks++; if (cur_lvl !== 2'd3) begin n_fail++; $display("FAIL dedup_final_lvl: got %0d want 3", cur_lvl); end
    endtask

    // Car at D: fill the queue while moving, then a press at full
    task automatic test_full;
        press_valid = 1'b1;
        press_lvl = 2'd1; step(1);
        press_lvl = 2'd2; step(1);
        press_lvl = 2'd3; step(1);
        press_lvl = 2'd0; step(1);
        press_valid = 1'b0;
        n_checks++; if (tail !== 3'd4) begin n_fail++; $display("FAIL full_tail: got %0d want 4", tail); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", full); end
        n_checks++; if (queue !== 8'b00_11_10_01) begin n_fail++; $display("FAIL full_queue: got %b want 00111001", queue); end
        n_checks++; if (moving !== 1'b1 || dir_up !== 1'b0) begin n_fail++; $display("FAIL full_dir_down: moving=%b dir_up=%b want 1,0", moving, dir_up); end
        step(1);
        press_valid = 1'b1; press_lvl = 2'd2;
        step(1);
        press_valid = 1'b0;
        n_checks++; if (tail !== 3'd4 || queue !== 8'b00_11_10_01) begin n_fail++; $display("FAIL full_press_ignored: tail=%0d queue=%b want 4,00111001", tail, queue); end
        wait_idle("full_drain");
        n_checks++; if (cur_lvl !== 2'd0) begin n_fail++; $display("FAIL full_final_lvl: got %0d want 0", cur_lvl); end
    endtask

    // Car at A: press D in the last DOOR cycle while queue is {B,C}
    task automatic test_simultaneous;
        bit seen;
        press_valid = 1'b1;
        press_lvl = 2'd1; step(1);
        press_lvl = 2'd2; step(1);
        press_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (door_open) begin seen = 1'b1; break; end
            step(1);
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL simul_door_timeout: door never opened"); end
        step(7);
        n_checks++; if (door_open !== 1'b1 || tail !== 3'd2 || queue[3:0] !== 4'b10_01) begin n_fail++; $display("FAIL simul_pre: door=%b tail=%0d q=%b want 1,2,1001", door_open, tail, queue[3:0]); end
        press_valid = 1'b1; press_lvl = 2'd3;
        step(1);
        press_valid = 1'b0;
        n_checks++; if (queue[3:0] !== 4'b11_10) begin n_fail++; $display("FAIL simul_queue: got %b want 1110", queue[3:0]); end
        n_checks++; if (tail !== 3'd2) begin n_fail++; $display("FAIL simul_tail: got %0d want 2", tail); end
        n_checks++; if (door_open !== 1'b0) begin n_fail++; $display("FAIL simul_door_closed: got %b want 0", door_open); end
        wait_idle("simul_drain");
        n_checks++; if (cur_lvl !== 2'd3) begin n_fail++; $display("FAIL simul_final_lvl: got %0d want 3", cur_lvl); end
    endtask

    // Reset while moving between levels discards everything
    task automatic test_reset_mid_move;
        bit seen;
        rst = 1'b1; step(1); rst = 1'b0;
        press_valid = 1'b1; press_lvl = 2'd3;
        step(1);
        press_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cur_lvl == 2'd1) begin seen = 1'b1; break; end
            step(1);
        end
        n_checks++; if (!seen || moving !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: reached=%b moving=%b want 1,1", seen, moving); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_checks++; if (cur_lvl !== 2'd0) begin n_fail++; $display("FAIL rstmid_lvl: got %0d want 0", cur_lvl); end
        n_checks++; if (tail !== 3'd0) begin n_fail++; $display("FAIL rstmid_tail: got %0d want 0", tail); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL rstmid_moving: got %b want 0", moving); end
        n_checks++; if (queue !== 8'd0) begin n_fail++; $display("FAIL rstmid_queue: got %h want 00", queue); end
        step(2);
        n_checks++; if (moving !== 1'b0 || cur_lvl !== 2'd0) begin n_fail++; $display("FAIL rstmid_stays: moving=%b lvl=%0d want 0,0", moving, cur_lvl); end
    endtask

    initial begin
        rst = 1'b1;
        press_valid = 1'b0;
        press_lvl = 2'd0;
        test_reset();
        test_single_trip();
        test_dedup();
        test_full();
        test_simultaneous();
        test_reset_mid_move();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
